// File: rtl/classifier_fc_stream.sv
// classifier_fc_stream
// Streaming fully-connected classifier head. Each frame is PIX beats of CH
// signed channel samples. Every beat is multiplied against a per-class weight
// column and accumulated into NCLS wide accumulators. After the last beat a bias
// is added, and a sequential argmax picks the winning class. The winner is
// reported with a one-cycle done pulse.
//
// Handshake: a beat transfers on a rising edge where valid_in and ready_in are
// both high. ready_in depends only on the FSM state (high in S_ACC). While
// ready_in is low, upstream keeps pixel_in stable and the beat is not consumed.
// valid_in never needs to wait for ready_in, and ready_in never waits for
// valid_in.
module classifier_fc_stream #(
    parameter int CH   = 4,
    parameter int PIX  = 49,
    parameter int NCLS = 10,
    parameter int DW   = 16,
    parameter int WW   = 16,
    parameter int BW   = 32,
    localparam int AW  = DW + WW + $clog2(CH * PIX) + 1,
    localparam int IW  = $clog2(NCLS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CH*DW-1:0]          pixel_in,
    input  logic                      valid_in,
    output logic                      ready_in,
    input  logic [NCLS*CH*PIX*WW-1:0] weight,
    input  logic [NCLS*BW-1:0]        bias,
    output logic [IW-1:0]             result,
    output logic [AW-1:0]             max_score,
    output logic                      done,
    output logic                      busy
);

    localparam int XW = $clog2(PIX);
    localparam logic [XW-1:0] IDX_LAST = XW'(PIX - 1);
    localparam logic [IW-1:0] K_LAST   = IW'(NCLS - 1);

    typedef enum logic [1:0] {
        S_ACC  = 2'd0,
        S_BIAS = 2'd1,
        S_ARG  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [XW-1:0]          idx_q, idx_d;
    logic [IW-1:0]          k_q, k_d;
    logic signed [AW-1:0]   acc_q [NCLS];
    logic signed [AW-1:0]   acc_d [NCLS];
    logic signed [AW-1:0]   best_q, best_d;
    logic [IW-1:0]          bidx_q, bidx_d;
    logic [IW-1:0]          result_q, result_d;
    logic [AW-1:0]          max_score_q, max_score_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;

    logic                   accept;
    logic signed [AW-1:0]   beat_sum [NCLS];
    logic signed [AW-1:0]   bias_ext [NCLS];
    logic signed [DW-1:0]   pix_c;
    logic signed [WW-1:0]   wgt_c;
    logic signed [DW+WW-1:0] prod_c;
    logic signed [AW-1:0]   cand_best;
    logic [IW-1:0]          cand_idx;

    assign ready_in  = (state_q == S_ACC);
    assign accept    = valid_in & ready_in;
    assign result    = result_q;
    assign max_score = max_score_q;
    assign done      = done_q;
    assign busy      = busy_q;

    // Per-class dot product of the current beat with weight column idx_q.
    always_comb begin
        pix_c  = '0;
        wgt_c  = '0;
        prod_c = '0;
        for (int k = 0; k < NCLS; k++) begin
            beat_sum[k] = '0;
            for (int c = 0; c < CH; c++) begin
                pix_c  = pixel_in[c*DW +: DW];
                wgt_c  = weight[((k*CH + c)*PIX + int'(idx_q))*WW +: WW];
                prod_c = (DW+WW)'(pix_c) * (DW+WW)'(wgt_c);
                beat_sum[k] = beat_sum[k] + AW'(prod_c);
            end
        end
    end

    // Sign-extend each class bias to the accumulator width.
    always_comb begin
        for (int k = 0; k < NCLS; k++) begin
            bias_ext[k] = AW'(signed'(bias[k*BW +: BW]));
        end
    end

    // Argmax step: a strictly greater score replaces the best, so ties keep the lower index.
    always_comb begin
        cand_best = best_q;
        cand_idx  = bidx_q;
        if (acc_q[k_q] > best_q) begin
            cand_best = acc_q[k_q];
            cand_idx  = k_q;
        end
    end

    // Next-state logic for the FSM, the accumulators and the registered outputs.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        k_d         = k_q;
        best_d      = best_q;
        bidx_d      = bidx_q;
        result_d    = result_q;
        max_score_d = max_score_q;
        done_d      = 1'b0;
        busy_d      = busy_q;
        for (int k = 0; k < NCLS; k++) begin
            acc_d[k] = acc_q[k];
        end

        case (state_q)
            S_ACC: begin
                if (accept) begin
                    for (int k = 0; k < NCLS; k++) begin
                        acc_d[k] = acc_q[k] + beat_sum[k];
                    end
                    busy_d = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = S_BIAS;
                    end else begin
                        idx_d = idx_q + XW'(1);
                    end
                end
            end
            S_BIAS: begin
                for (int k = 0; k < NCLS; k++) begin
                    acc_d[k] = acc_q[k] + bias_ext[k];
                end
                best_d  = acc_d[0];
                bidx_d  = '0;
                k_d     = IW'(1);
                state_d = S_ARG;
            end
            S_ARG: begin
                best_d = cand_best;
                bidx_d = cand_idx;
                if (k_q == K_LAST) begin
                    result_d    = cand_idx;
                    max_score_d = cand_best;
                    done_d      = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    k_d = k_q + IW'(1);
                end
            end
            S_DONE: begin
                // Clear the accumulators so the next frame starts from zero.
                for (int k = 0; k < NCLS; k++) begin
                    acc_d[k] = '0;
                end
                busy_d  = 1'b0;
                state_d = S_ACC;
            end
            default: begin
                state_d = S_ACC;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_ACC;
            idx_q       <= '0;
            k_q         <= '0;
            best_q      <= '0;
            bidx_q      <= '0;
            result_q    <= '0;
            max_score_q <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            for (int k = 0; k < NCLS; k++) begin
                acc_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            k_q         <= k_d;
            best_q      <= best_d;
            bidx_q      <= bidx_d;
            result_q    <= result_d;
            max_score_q <= max_score_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            for (int k = 0; k < NCLS; k++) begin
                acc_q[k] <= acc_d[k];
            end
        end
    end

endmodule

// File: tb/tb_classifier_fc_stream.sv
// Directed bench for classifier_fc_stream: a default instance (4x49x10) and a
// small instance (2x9x3). Expected scores come from a plain dot-product model.
module tb_classifier_fc_stream;

    localparam int CH_A = 4, PIX_A = 49, NC_A = 10, AW_A = 41, IW_A = 4;
    localparam int CH_B = 2, PIX_B = 9,  NC_B = 3,  AW_B = 38, IW_B = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic [CH_A*16-1:0]          pix_a;
    logic                        valid_a, ready_a, done_a, busy_a;
    logic [NC_A*CH_A*PIX_A*16-1:0] weight_a;
    logic [NC_A*32-1:0]          bias_a;
    logic [IW_A-1:0]             result_a;
    logic [AW_A-1:0]             max_a;

    logic [CH_B*16-1:0]          pix_b;
    logic                        valid_b, ready_b, done_b, busy_b;
    logic [NC_B*CH_B*PIX_B*16-1:0] weight_b;
    logic [NC_B*32-1:0]          bias_b;
    logic [IW_B-1:0]             result_b;
    logic [AW_B-1:0]             max_b;

    classifier_fc_stream dut_a (
        .clk(clk), .reset(reset), .pixel_in(pix_a), .valid_in(valid_a), .ready_in(ready_a),
        .weight(weight_a), .bias(bias_a), .result(result_a), .max_score(max_a),
        .done(done_a), .busy(busy_a)
    );

    classifier_fc_stream #(.CH(CH_B), .PIX(PIX_B), .NCLS(NC_B)) dut_b (
        .clk(clk), .reset(reset), .pixel_in(pix_b), .valid_in(valid_b), .ready_in(ready_b),
        .weight(weight_b), .bias(bias_b), .result(result_b), .max_score(max_b),
        .done(done_b), .busy(busy_b)
    );

    int checks = 0;
    int errors = 0;
    int drops = 0;
    int busy_bad = 0;

    int wa [NC_A][CH_A][PIX_A];
    int pa [2][PIX_A][CH_A];
    int ba [NC_A];
    int wb [NC_B][CH_B][PIX_B];
    int pb [2][PIX_B][CH_B];
    int bb [NC_B];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int rnd16();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic pack_a();
        for (int k = 0; k < NC_A; k++) begin
            bias_a[k*32 +: 32] = ba[k];
            for (int c = 0; c < CH_A; c++)
                for (int p = 0; p < PIX_A; p++)
                    weight_a[((k*CH_A + c)*PIX_A + p)*16 +: 16] = 16'(wa[k][c][p]);
        end
    endtask

    task automatic pack_b();
        for (int k = 0; k < NC_B; k++) begin
            bias_b[k*32 +: 32] = bb[k];
            for (int c = 0; c < CH_B; c++)
                for (int p = 0; p < PIX_B; p++)
                    weight_b[((k*CH_B + c)*PIX_B + p)*16 +: 16] = 16'(wb[k][c][p]);
        end
    endtask

    task automatic model_a(input int f, output int res, output longint sc);
        longint s;
        res = 0;
        sc  = 0;
        for (int k = 0; k < NC_A; k++) begin
            s = longint'(ba[k]);
            for (int p = 0; p < PIX_A; p++)
                for (int c = 0; c < CH_A; c++)
                    s += longint'(pa[f][p][c]) * longint'(wa[k][c][p]);
            if (k == 0 || s > sc) begin
                sc  = s;
                res = k;
            end
        end
    endtask

    task automatic model_b(input int f, output int res, output longint sc);
        longint s;
        res = 0;
        sc  = 0;
        for (int k = 0; k < NC_B; k++) begin
            s = longint'(bb[k]);
            for (int p = 0; p < PIX_B; p++)
                for (int c = 0; c < CH_B; c++)
                    s += longint'(pb[f][p][c]) * longint'(wb[k][c][p]);
            if (k == 0 || s > sc) begin
                sc  = s;
                res = k;
            end
        end
    endtask

    // Feeds nbeats of frame f; returns how many cycles beat 0 waited for ready.
    task automatic feed_a(input int f, input int nbeats, input bit gaps, input bit keep_valid,
                          output int first_wait);
        int waited;
        first_wait = 0;
        for (int p = 0; p < nbeats; p++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                valid_a = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk); #1;
                    if (p != 0 && !ready_a) drops++;
                end
            end
            for (int c = 0; c < CH_A; c++) pix_a[c*16 +: 16] = 16'(pa[f][p][c]);
            valid_a = 1'b1;
            waited = 0;
            while (!ready_a && waited < 200) begin
                @(posedge clk); #1;
                waited++;
            end
            if (p == 0) begin
                first_wait = waited;
                if (busy_a) busy_bad++;
            end else if (waited != 0) begin
                drops++;
            end
            @(posedge clk); #1;
            if (p == 0 && !busy_a) busy_bad++;
        end
        if (!keep_valid) valid_a = 1'b0;
    endtask

    task automatic feed_b(input int f, input bit keep_valid, output int first_wait);
        int waited;
        first_wait = 0;
        for (int p = 0; p < PIX_B; p++) begin
            for (int c = 0; c < CH_B; c++) pix_b[c*16 +: 16] = 16'(pb[f][p][c]);
            valid_b = 1'b1;
            waited = 0;
            while (!ready_b && waited < 200) begin
                @(posedge clk); #1;
                waited++;
            end
            if (p == 0) begin
                first_wait = waited;
                if (busy_b) busy_bad++;
            end else if (waited != 0) begin
                drops++;
            end
            @(posedge clk); #1;
            if (p == 0 && !busy_b) busy_bad++;
        end
        if (!keep_valid) valid_b = 1'b0;
    endtask

    // Called #1 after the edge that accepted the last beat. lat is the number of
    // further edges until done is seen, i.e. done lives in cycle lat+1 after accept.
    task automatic wait_done_a(output int lat, output int rdy_bad);
        int n;
        lat = -1;
        n = 0;
        rdy_bad = ready_a ? 1 : 0;
        while (n < 100 && lat < 0) begin
            @(posedge clk); #1;
            n++;
            if (done_a) lat = n;
            if (ready_a) rdy_bad++;
        end
    endtask

    task automatic wait_done_b(output int lat, output int rdy_bad);
        int n;
        lat = -1;
        n = 0;
        rdy_bad = ready_b ? 1 : 0;
        while (n < 100 && lat < 0) begin
            @(posedge clk); #1;
            n++;
            if (done_b) lat = n;
            if (ready_b) rdy_bad++;
        end
    endtask

    // Runs one complete default-instance frame and checks its outcome.
    task automatic frame_a(input string tag, input int f, input bit gaps,
                           input int exp_res, input longint exp_sc);
        int fw, lat, rb;
        feed_a(f, PIX_A, gaps, 1'b0, fw);
        wait_done_a(lat, rb);
        check({tag, "_latency"}, 64'(lat), 64'(NC_A));
        check({tag, "_ready_low"}, 64'(rb), 64'd0);
        check({tag, "_result"}, 64'(result_a), 64'(exp_res));
        check({tag, "_max"}, 64'(max_a), 64'(exp_sc[AW_A-1:0]));
        check({tag, "_busy_at_done"}, 64'(busy_a), 64'd1);
        @(posedge clk); #1;
        check({tag, "_done_width"}, 64'(done_a), 64'd0);
        check({tag, "_ready_back"}, 64'(ready_a), 64'd1);
        check({tag, "_busy_after"}, 64'(busy_a), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, r1, fw, lat, rb, seen;
        longint s0, s1;

        reset = 1'b0;
        valid_a = 1'b0; pix_a = '0; weight_a = '0; bias_a = '0;
        valid_b = 1'b0; pix_b = '0; weight_b = '0; bias_b = '0;
        for (int k = 0; k < NC_A; k++)
            for (int c = 0; c < CH_A; c++)
                for (int p = 0; p < PIX_A; p++) wa[k][c][p] = rnd16();
        for (int f = 0; f < 2; f++)
            for (int p = 0; p < PIX_A; p++)
                for (int c = 0; c < CH_A; c++) pa[f][p][c] = 0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_result", 64'(result_a), 64'd0);
        check("rst_max", 64'(max_a), 64'd0);
        check("rst_done", 64'(done_a), 64'd0);
        check("rst_busy", 64'(busy_a), 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_ready", 64'(ready_a), 64'd1);

        // Zero pixels, bias[7]=500: class 7 wins with 500.
        for (int k = 0; k < NC_A; k++) ba[k] = 0;
        ba[7] = 500;
        pack_a();
        frame_a("t1", 0, 1'b0, 7, 64'sd500);

        // Tie between classes 2 and 5 resolves to the lower index.
        for (int k = 0; k < NC_A; k++) ba[k] = -1;
        ba[2] = 100;
        ba[5] = 100;
        pack_a();
        frame_a("t2", 0, 1'b0, 2, 64'sd100);

        // Random frame, contiguous and then with valid gaps.
        for (int p = 0; p < PIX_A; p++)
            for (int c = 0; c < CH_A; c++) pa[0][p][c] = rnd16();
        for (int k = 0; k < NC_A; k++) ba[k] = int'($urandom_range(0, 200000)) - 100000;
        pack_a();
        model_a(0, r0, s0);
        drops = 0;
        frame_a("t3_contig", 0, 1'b0, r0, s0);
        frame_a("t3_gaps", 0, 1'b1, r0, s0);
        check("t3_no_ready_drop", 64'(drops), 64'd0);

        // Extremes: 196 products of 2^30 each.
        for (int k = 0; k < NC_A; k++) begin
            ba[k] = 0;
            for (int c = 0; c < CH_A; c++)
                for (int p = 0; p < PIX_A; p++) wa[k][c][p] = -32768;
        end
        for (int p = 0; p < PIX_A; p++)
            for (int c = 0; c < CH_A; c++) pa[0][p][c] = -32768;
        pack_a();
        frame_a("t4", 0, 1'b0, 0, 64'sd210453397504);

        // Reset after 20 beats: outputs clear, no done, next frame correct.
        for (int k = 0; k < NC_A; k++)
            for (int c = 0; c < CH_A; c++)
                for (int p = 0; p < PIX_A; p++) wa[k][c][p] = rnd16();
        for (int p = 0; p < PIX_A; p++)
            for (int c = 0; c < CH_A; c++) pa[0][p][c] = rnd16();
        for (int k = 0; k < NC_A; k++) ba[k] = int'($urandom_range(0, 2000)) - 1000;
        pack_a();
        feed_a(0, 20, 1'b0, 1'b0, fw);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        check("t5_result", 64'(result_a), 64'd0);
        check("t5_max", 64'(max_a), 64'd0);
        check("t5_busy", 64'(busy_a), 64'd0);
        check("t5_ready", 64'(ready_a), 64'd1);
        seen = 0;
        repeat (NC_A + 40) begin
            @(posedge clk); #1;
            if (done_a) seen++;
        end
        check("t5_no_done", 64'(seen), 64'd0);
        model_a(0, r0, s0);
        frame_a("t5_after", 0, 1'b0, r0, s0);

        // Back-to-back frames with valid held high.
        for (int f = 0; f < 2; f++)
            for (int p = 0; p < PIX_A; p++)
                for (int c = 0; c < CH_A; c++) pa[f][p][c] = rnd16();
        model_a(0, r0, s0);
        model_a(1, r1, s1);
        busy_bad = 0;
        feed_a(0, PIX_A, 1'b0, 1'b1, fw);
        for (int c = 0; c < CH_A; c++) pix_a[c*16 +: 16] = 16'(pa[1][0][c]);
        wait_done_a(lat, rb);
        check("t6_f0_latency", 64'(lat), 64'(NC_A));
        check("t6_f0_result", 64'(result_a), 64'(r0));
        check("t6_f0_max", 64'(max_a), 64'(s0[AW_A-1:0]));
        feed_a(1, PIX_A, 1'b0, 1'b0, fw);
        check("t6_f1_start", 64'(fw), 64'd1);
        wait_done_a(lat, rb);
        check("t6_f1_latency", 64'(lat), 64'(NC_A));
        check("t6_f1_result", 64'(result_a), 64'(r1));
        check("t6_f1_max", 64'(max_a), 64'(s1[AW_A-1:0]));
        check("t6_busy_edges", 64'(busy_bad), 64'd0);

        // Small instance: back-to-back frames with valid held high.
        for (int k = 0; k < NC_B; k++) begin
            bb[k] = int'($urandom_range(0, 2000)) - 1000;
            for (int c = 0; c < CH_B; c++)
                for (int p = 0; p < PIX_B; p++) wb[k][c][p] = rnd16();
        end
        for (int f = 0; f < 2; f++)
            for (int p = 0; p < PIX_B; p++)
                for (int c = 0; c < CH_B; c++) pb[f][p][c] = rnd16();
        pack_b();
        model_b(0, r0, s0);
        model_b(1, r1, s1);
        busy_bad = 0;
        drops = 0;
        feed_b(0, 1'b1, fw);
        for (int c = 0; c < CH_B; c++) pix_b[c*16 +: 16] = 16'(pb[1][0][c]);
        wait_done_b(lat, rb);
        check("b_f0_latency", 64'(lat), 64'(NC_B));
        check("b_f0_ready_low", 64'(rb), 64'd0);
        check("b_f0_result", 64'(result_b), 64'(r0));
        check("b_f0_max", 64'(max_b), 64'(s0[AW_B-1:0]));
        feed_b(1, 1'b0, fw);
        check("b_f1_start", 64'(fw), 64'd1);
        wait_done_b(lat, rb);
        check("b_f1_latency", 64'(lat), 64'(NC_B));
        check("b_f1_result", 64'(result_b), 64'(r1));
        check("b_f1_max", 64'(max_b), 64'(s1[AW_B-1:0]));
        @(posedge clk); #1;
        check("b_done_width", 64'(done_b), 64'd0);
        check("b_busy_edges", 64'(busy_bad), 64'd0);
        check("b_no_ready_drop", 64'(drops), 64'd0);

        // Small instance tie: zero pixels, bias 7/7/3 -> class 0.
        bb[0] = 7; bb[1] = 7; bb[2] = 3;
        for (int p = 0; p < PIX_B; p++)
            for (int c = 0; c < CH_B; c++) pb[0][p][c] = 0;
        pack_b();
        feed_b(0, 1'b0, fw);
        wait_done_b(lat, rb);
        check("b_tie_result", 64'(result_b), 64'd0);
        check("b_tie_max", 64'(max_b), 64'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
